// File: rtl/diffeq_pkg.sv
// Shared definitions for the differential-equation solver: controller state codes
// and default fixed-point geometry.
package diffeq_pkg;

  localparam int DEF_W    = 16;
  localparam int DEF_FRAC = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_COMPUTE_1 = 3'd2,
    S_COMPUTE_2 = 3'd3,
    S_COMPUTE_3 = 3'd4,
    S_COMPUTE_4 = 3'd5,
    S_DONE      = 3'd6
  } state_e;

endpackage

// File: rtl/diffeq_mul.sv
// Pipelined signed fixed-point multiplier; a valid bit travels with each product
// and flush_i kills everything already in flight (a same-cycle issue survives).
module diffeq_mul #(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int LAT  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         valid_o,
  output logic [W-1:0] p_o
);

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;
  logic signed [2*W-1:0] prod;
  logic [W-1:0]          data_q [LAT];
  logic [LAT-1:0]        valid_q;
  logic                  prod_unused;

  assign a_ext = {{W{a_i[W-1]}}, a_i};
  assign b_ext = {{W{b_i[W-1]}}, b_i};
  assign prod  = a_ext * b_ext;
  // Only bits FRAC..FRAC+W-1 survive the shift-and-truncate; the rest wrap away.
  assign prod_unused = ^prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= prod[FRAC +: W];
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush_i;
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign p_o     = data_q[LAT-1];

endmodule

// File: rtl/diffeq_datapath.sv
// Datapath for the loop  x += dx; y += u*dx; u -= 3x*u*dx + 3y*dx  while x < a,
// sharing one pipelined multiplier across compute steps C1..C3.
module diffeq_datapath
  import diffeq_pkg::*;
#(
  parameter int           W       = DEF_W,
  parameter int           FRAC    = DEF_FRAC,
  parameter int           MUL_LAT = 2,
  parameter logic [W-1:0] Y_INIT  = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   state,
  input  logic         load_x,
  input  logic         load_dx,
  input  logic         load_a,
  input  logic         load_u,
  input  logic [W-1:0] data_in,
  output logic         compute_done,
  output logic         continue_while,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] u_out
);

  logic [W-1:0] x_q, x_d, dx_q, dx_d, a_q, a_d, u_q, u_d, y_q, y_d;
  logic [W-1:0] t_udx_q, t_udx_d, t_3x_q, t_3x_d, t_a_q, t_a_d, t_b_q, t_b_d;
  logic [2:0]   prev_state_q;
  logic         in_step, state_changed, issue, result_ok;
  logic [W-1:0] op_a, op_b, y_3x, mul_p;
  logic         mul_valid;
  logic         t_b_unused;

  assign in_step = (state == S_COMPUTE_1) || (state == S_COMPUTE_2) ||
                   (state == S_COMPUTE_3);
  assign state_changed = (state != prev_state_q);
  assign issue         = in_step && state_changed;
  // A result only counts if the step that issued it is still the current one.
  assign result_ok     = mul_valid && in_step && !state_changed;
  assign y_3x          = y_q + (y_q << 1);
  assign t_b_unused    = ^t_b_q;

  always_comb begin
    op_a = u_q;
    op_b = dx_q;
    case (state)
      S_COMPUTE_2: begin op_a = t_3x_q; op_b = t_udx_q; end
      S_COMPUTE_3: begin op_a = y_3x;   op_b = dx_q;    end
      default: ;
    endcase
  end

  diffeq_mul #(.W(W), .FRAC(FRAC), .LAT(MUL_LAT)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .flush_i (state_changed),
    .valid_i (issue),
    .a_i     (op_a),
    .b_i     (op_b),
    .valid_o (mul_valid),
    .p_o     (mul_p)
  );

  always_comb begin
    x_d     = x_q;
    dx_d    = dx_q;
    a_d     = a_q;
    u_d     = u_q;
    y_d     = y_q;
    t_udx_d = t_udx_q;
    t_3x_d  = t_3x_q;
    t_a_d   = t_a_q;
    t_b_d   = t_b_q;
    if (state == S_READ) begin
      if (load_x)  x_d  = data_in;
      if (load_dx) dx_d = data_in;
      if (load_a)  a_d  = data_in;
      if (load_u)  u_d  = data_in;
      y_d = Y_INIT;
    end
    if (issue && (state == S_COMPUTE_1)) t_3x_d = x_q + (x_q << 1);
    if (result_ok) begin
      case (state)
        S_COMPUTE_1: t_udx_d = mul_p;
        S_COMPUTE_2: t_a_d   = mul_p;
        S_COMPUTE_3: begin
          t_b_d = mul_p;
          x_d   = x_q + dx_q;
          y_d   = y_q + t_udx_q;
          u_d   = u_q - t_a_q - mul_p;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      dx_q         <= '0;
      a_q          <= '0;
      u_q          <= '0;
      y_q          <= Y_INIT;
      t_udx_q      <= '0;
      t_3x_q       <= '0;
      t_a_q        <= '0;
      t_b_q        <= '0;
      prev_state_q <= '0;
    end else begin
      x_q          <= x_d;
      dx_q         <= dx_d;
      a_q          <= a_d;
      u_q          <= u_d;
      y_q          <= y_d;
      t_udx_q      <= t_udx_d;
      t_3x_q       <= t_3x_d;
      t_a_q        <= t_a_d;
      t_b_q        <= t_b_d;
      prev_state_q <= state;
    end
  end

  assign continue_while = $signed(x_q) < $signed(a_q);

  // C1..C3 report the registered result-valid; C4 reports the exit test directly.
  always_comb begin
    compute_done = 1'b0;
    if (in_step)                   compute_done = result_ok;
    else if (state == S_COMPUTE_4) compute_done = !continue_while;
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign u_out = u_q;

endmodule

// File: tb/tb_diffeq_datapath.sv
// Directed and randomized checks of diffeq_datapath against a plain-arithmetic
// model of one solver iteration.
module tb_diffeq_datapath;
  import diffeq_pkg::*;

  localparam int           W       = 16;
  localparam int           FRAC    = 8;
  localparam int           MUL_LAT = 2;
  localparam logic [W-1:0] Y_INIT  = 16'h0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   state;
  logic         load_x, load_dx, load_a, load_u;
  logic [W-1:0] data_in;
  logic         compute_done, continue_while;
  logic [W-1:0] x_out, y_out, u_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mx, my, mu, mdx, ma;

  diffeq_datapath #(.W(W), .FRAC(FRAC), .MUL_LAT(MUL_LAT), .Y_INIT(Y_INIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .state          (state),
    .load_x         (load_x),
    .load_dx        (load_dx),
    .load_a         (load_a),
    .load_u         (load_u),
    .data_in        (data_in),
    .compute_done   (compute_done),
    .continue_while (continue_while),
    .x_out          (x_out),
    .y_out          (y_out),
    .u_out          (u_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fmul(input logic [W-1:0] p, input logic [W-1:0] q);
    longint prod;
    prod = longint'($signed(p)) * longint'($signed(q));
    prod = prod >>> FRAC;
    return prod[W-1:0];
  endfunction

  function automatic logic [W-1:0] times3(input logic [W-1:0] v);
    return W'(3 * int'($signed(v)));
  endfunction

  task automatic model_iter();
    logic [W-1:0] udx, ta, tb;
    udx = fmul(mu, mdx);
    ta  = fmul(times3(mx), udx);
    tb  = fmul(times3(my), mdx);
    mx  = mx + mdx;
    my  = my + udx;
    mu  = mu - ta - tb;
  endtask

  task automatic do_load(input logic [W-1:0] vx, input logic [W-1:0] vdx,
                         input logic [W-1:0] va, input logic [W-1:0] vu);
    state = S_READ;
    load_x  = 1'b1; data_in = vx;  tick(); load_x  = 1'b0;
    load_dx = 1'b1; data_in = vdx; tick(); load_dx = 1'b0;
    load_a  = 1'b1; data_in = va;  tick(); load_a  = 1'b0;
    load_u  = 1'b1; data_in = vu;  tick(); load_u  = 1'b0;
    mx = vx; mdx = vdx; ma = va; mu = vu; my = Y_INIT;
    chk("load_x", x_out, mx);
    chk("load_u", u_out, mu);
    chk("load_y", y_out, my);
    chk("load_cw", W'(continue_while), W'($signed(mx) < $signed(ma)));
  endtask

  task automatic do_step(input string tag, input logic [2:0] st, input bit poke);
    state = st;
    if (poke) begin
      load_x  = 1'b1;
      data_in = 16'h1234;
    end
    #1;
    for (int k = 0; k <= MUL_LAT; k++) begin
      chk($sformatf("%s_st%0d_pulse_c%0d", tag, st, k), W'(compute_done), W'(k == MUL_LAT));
      if (k < MUL_LAT) tick();
    end
    if (poke) begin
      chk($sformatf("%s_load_ignored", tag), x_out, mx);
      load_x = 1'b0;
    end
    tick();
  endtask

  task automatic run_iter(input string tag, input bit poke, output bit done);
    do_step(tag, S_COMPUTE_1, poke);
    do_step(tag, S_COMPUTE_2, 1'b0);
    do_step(tag, S_COMPUTE_3, 1'b0);
    model_iter();
    done  = ($signed(mx) >= $signed(ma));
    state = S_COMPUTE_4;
    #1;
    chk($sformatf("%s_c4_done", tag), W'(compute_done), W'(done));
    chk($sformatf("%s_c4_cw", tag), W'(continue_while), W'(!done));
    chk($sformatf("%s_x", tag), x_out, mx);
    chk($sformatf("%s_y", tag), y_out, my);
    chk($sformatf("%s_u", tag), u_out, mu);
    $display("iter %s: x=%h y=%h u=%h exit=%0d", tag, x_out, y_out, u_out, compute_done);
    tick();
  endtask

  initial begin
    bit d;
    int rx, rdx, ra, ru, it;

    state = S_IDLE; load_x = 0; load_dx = 0; load_a = 0; load_u = 0;
    data_in = '0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_x", x_out, 16'h0000);
    chk("rst_y", y_out, Y_INIT);
    chk("rst_u", u_out, 16'h0000);
    chk("rst_cd", W'(compute_done), 16'h0000);
    chk("rst_cw", W'(continue_while), 16'h0000);

    // Multiple strobes at once, then an asynchronous mid-cycle reset.
    state = S_READ; load_x = 1; load_u = 1; data_in = 16'h0055;
    tick();
    load_x = 0; load_u = 0;
    chk("multi_x", x_out, 16'h0055);
    chk("multi_u", u_out, 16'h0055);
    #3;
    reset = 1'b1;
    #1;
    chk("async_x", x_out, 16'h0000);
    chk("async_u", u_out, 16'h0000);
    chk("async_y", y_out, Y_INIT);
    chk("async_cd", W'(compute_done), 16'h0000);
    tick();
    reset = 1'b0;
    state = S_IDLE;
    tick();

    // Directed two-iteration run.
    do_load(16'h0000, 16'h0040, 16'h0080, 16'h0100);
    run_iter("it1", 1'b1, d);
    chk("it1_x_const", x_out, 16'h0040);
    chk("it1_y_const", y_out, 16'h0040);
    chk("it1_u_const", u_out, 16'h0100);
    chk("it1_cd_const", W'(compute_done), 16'h0000);
    run_iter("it2", 1'b0, d);
    chk("it2_x_const", x_out, 16'h0080);
    chk("it2_y_const", y_out, 16'h0080);
    chk("it2_u_const", u_out, 16'h00A0);
    chk("it2_cd_const", W'(compute_done), 16'h0001);
    state = S_DONE;
    #1;
    chk("done_cd", W'(compute_done), 16'h0000);
    tick();

    // Immediate exit after one iteration.
    do_load(16'h0000, 16'h0040, 16'h0000, 16'h0100);
    run_iter("imm", 1'b0, d);
    chk("imm_x_const", x_out, 16'h0040);
    chk("imm_cd_const", W'(compute_done), 16'h0001);
    state = S_DONE; tick();

    // Signed wrap of x.
    do_load(16'h7FC0, 16'h0080, 16'h7FFF, 16'h0010);
    run_iter("wrap", 1'b0, d);
    chk("wrap_x_const", x_out, 16'h8040);
    chk("wrap_cw_const", W'(continue_while), 16'h0001);
    chk("wrap_cd_const", W'(compute_done), 16'h0000);
    state = S_DONE; tick();

    // Randomized solver runs.
    for (int r = 0; r < 8; r++) begin
      rdx = int'($urandom_range(16, 128));
      rx  = int'($urandom_range(0, 512)) - 256;
      ra  = rx + rdx * int'($urandom_range(0, 3)) + int'($urandom_range(0, 15));
      ru  = int'($urandom_range(0, 1023)) - 512;
      do_load(W'(rx), W'(rdx), W'(ra), W'(ru));
      it = 0;
      d  = 1'b0;
      while (!d && it < 5) begin
        run_iter($sformatf("rnd%0d_%0d", r, it), 1'b0, d);
        it++;
      end
      state = S_DONE; tick();
    end

    // Reset during C2 after the multiply was issued.
    do_load(16'h0000, 16'h0040, 16'h0080, 16'h0100);
    do_step("ab", S_COMPUTE_1, 1'b0);
    state = S_COMPUTE_2;
    tick();
    #3;
    reset = 1'b1;
    state = S_IDLE;
    #1;
    chk("ab_x", x_out, 16'h0000);
    chk("ab_y", y_out, Y_INIT);
    chk("ab_u", u_out, 16'h0000);
    chk("ab_cd", W'(compute_done), 16'h0000);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ab_post_cd%0d", k), W'(compute_done), 16'h0000);
      chk($sformatf("ab_post_u%0d", k), u_out, 16'h0000);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/diffeq_datapath.md
Name: diffeq_datapath

Overview:
Fixed-point datapath for the differential-equation solver loop (while x < a: x += dx; y += u·dx; u -= 3x·u·dx + 3y·dx), sitting directly downstream of the solver controller. It consumes the controller's state code, load strobes and the shared input bus. It returns compute_done (step finished / loop exit) and continue_while (x < a) to the controller. A single shared pipelined multiplier is time-multiplexed over the three multiply steps.

Parameters:
W, 16, data width of all operands and registers, signed two's complement
FRAC, 8, fractional bits (Q(W-FRAC).FRAC)
MUL_LAT, 2, multiplier pipeline latency in cycles, legal range 1..4
Y_INIT, 0, initial value of y at reset and in S_READ

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-high reset
state  in  3  controller state code (S_IDLE..S_DONE)
load_x  in  1  capture data_in into x (honoured only in S_READ)
load_dx  in  1  capture data_in into dx (S_READ only)
load_a  in  1  capture data_in into a (S_READ only)
load_u  in  1  capture data_in into u (S_READ only)
data_in  in  W  operand input bus
compute_done  out  1  C1–C3: one-cycle step-complete pulse; C4: loop-exit flag
continue_while  out  1  combinational signed (x < a)
x_out  out  W  current x register
y_out  out  W  current y register
u_out  out  W  current u register

Behaviour:
- Reset: clear x, dx, a, u, temporaries T_UDX, T_3X, T_A, T_B, prev_state and all multiplier valid bits to 0; set y to Y_INIT. compute_done reads 0; continue_while reads 0 (0 < 0 false).
- Loads: in S_READ, each clock with load_* high writes data_in into that register. Multiple strobes high at once write all selected registers. Loads are ignored in all other states. y is set to Y_INIT every S_READ cycle.
- Step entry: a clock where state != prev_state and state ∈ {C1,C2,C3} issues one multiply. prev_state follows state every cycle.
- Multiply: signed W×W → 2W product, arithmetic shift right by FRAC, truncate to W (wraps, no saturation). The result is valid MUL_LAT cycles after issue.
- C1: issue u·dx. Compute T_3X = x + (x<<1), wrapped to W, at issue. Capture T_UDX on result.
- C2: issue T_3X·T_UDX. Capture T_A.
- C3: issue (y + (y<<1))·dx. On result, capture T_B and commit in the same edge: x ← x+dx, y ← y+T_UDX, u ← u−T_A−T_B, all wrapped to W.
- compute_done in C1–C3: registered. High exactly in cycle entry+MUL_LAT, i.e. each step occupies MUL_LAT+1 cycles; low in every other cycle.
- C4: single cycle, no multiply. compute_done = (x ≥ a) signed, combinational, on committed x. Low keeps the loop going (controller returns to C1); high ends it (S_DONE).
- In IDLE, READ and DONE, compute_done is 0.
- Abort: if state leaves a compute state before its result arrives, discard the in-flight result. No capture, no commit, no pulse.
- Reset mid-operation: pipeline flushed, registers cleared as above, no partial commit.

Decomposition:
- Package diffeq_pkg: state codes S_IDLE=0, S_READ=1, S_COMPUTE_1..4=2..5, S_DONE=6, shared with the controller; default W/FRAC.
- Sub-module diffeq_mul: MUL_LAT-stage signed fixed-point multiplier with a valid bit travelling alongside the data. It takes the same clk/reset and a flush input driven on abort.

Test Plan (W=16, FRAC=8, MUL_LAT=2):
- Reset: assert reset mid-cycle → all outputs 0, y_out=Y_INIT, compute_done=0, asynchronously.
- Loads: READ with x=0x0000, dx=0x0040, a=0x0080, u=0x0100, one strobe per cycle. Then drive load_x high in C1 with data_in=0x1234 → x unchanged.
- Two-iteration run from those values:
  - Iteration 1 ends x=0x0040, y=0x0040, u=0x0100; C4 compute_done=0, continue_while=1.
  - Iteration 2 ends x=0x0080, y=0x0080, u=0x00A0; C4 compute_done=1.
  - Each C1–C3 pulse arrives 2 cycles after entry.
- Immediate exit: a=0x0000, x=0, dx=0x0040 → one iteration, x=0x0040, C4 compute_done=1.
- Abort: reset during C2 after issue → no T_A capture, x/u/y cleared, no compute_done pulse after reset release.
- Wrap: x=0x7FC0, dx=0x0080, a=0x7FFF → x commits 0x8040 (negative), continue_while=1, C4 compute_done=0.
